id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 178 +++++++++++++++++
 tb/tb_id_stage.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction decode stage: decodes OP / OP-IMM / LUI / LOAD, reads the
// register file, detects EX hazards and registers the decoded fields for EX.
// Build option: define ID_FWD_EN to forward non-load EX results into ID
// (only load-use then stalls); without it every EX match stalls.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    output logic        re1,
    output logic [4:0]  raddr1,
    input  logic [31:0] rdata1,
    output logic        re2,
    output logic [4:0]  raddr2,
    input  logic [31:0] rdata2,
    input  logic        ex_wreg,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    input  logic        ex_is_load,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_op1,
    output logic [31:0] id_op2,
    output logic [4:0]  id_waddr,
    output logic        id_wreg,
    output logic [3:0]  id_alu_op,
    output logic        id_is_load,
    output logic        id_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR   = 4'd8, ALU_AND = 4'd9
    } aluOp_t;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic [31:0] w_immI;
    logic [31:0] w_shamt;
    logic [31:0] w_immU;
    logic        w_isOp, w_isOpImm, w_isLui, w_isLoad, w_legal;
    logic        w_match1, w_match2, w_hazard, w_loadEn;
    logic [31:0] w_src1, w_src2, w_op1, w_op2;
    aluOp_t      w_aluOp;

    logic        r_valid;
    logic [31:0] r_pc, r_op1, r_op2;
    logic [4:0]  r_waddr;
    logic        r_wreg, r_isLoad, r_illegal;
    aluOp_t      r_aluOp;

    assign w_opcode  = if_inst[6:0];
    assign w_funct3  = if_inst[14:12];
    assign w_rd      = if_inst[11:7];
    assign w_immI    = {{20{if_inst[31]}}, if_inst[31:20]};
    assign w_shamt   = {27'd0, if_inst[24:20]};
    assign w_immU    = {if_inst[31:12], 12'd0};

    assign w_isOp    = (w_opcode == OPC_OP);
    assign w_isOpImm = (w_opcode == OPC_OP_IMM);
    assign w_isLui   = (w_opcode == OPC_LUI);
    assign w_isLoad  = (w_opcode == OPC_LOAD);
    assign w_legal   = w_isOp | w_isOpImm | w_isLui | w_isLoad;

    assign re1    = w_isOp | w_isOpImm | w_isLoad;
    assign re2    = w_isOp;
    assign raddr1 = if_inst[19:15];
    assign raddr2 = if_inst[24:20];

    // x0 never matches: it is a constant and cannot be a hazard source
    assign w_match1 = re1 && (raddr1 != 5'd0) && ex_wreg && (ex_waddr == raddr1);
    assign w_match2 = re2 && (raddr2 != 5'd0) && ex_wreg && (ex_waddr == raddr2);

`ifdef ID_FWD_EN
    assign w_hazard = if_valid && (w_match1 || w_match2) && ex_is_load;
    assign w_src1   = (raddr1 == 5'd0) ? 32'd0 : (w_match1 && !ex_is_load) ? ex_wdata : rdata1;
    assign w_src2   = (raddr2 == 5'd0) ? 32'd0 : (w_match2 && !ex_is_load) ? ex_wdata : rdata2;
`else
    logic w_unusedFwd;
    assign w_unusedFwd = ^{ex_wdata, ex_is_load};
    assign w_hazard = if_valid && (w_match1 || w_match2);
    assign w_src1   = (raddr1 == 5'd0) ? 32'd0 : rdata1;
    assign w_src2   = (raddr2 == 5'd0) ? 32'd0 : rdata2;
`endif

    // The output register may advance when it is empty or EX is taking it;
    // a flush always frees the fetch side so the incoming word is dropped.
    assign w_loadEn = !r_valid || ex_ready;
    assign if_ready = rst && (flush || (w_loadEn && !w_hazard));

    // ALU operation from funct3; bit 30 selects SUB (OP only) and SRA
    always_comb begin
        w_aluOp = ALU_ADD;
        if (w_isOp || w_isOpImm) begin
            case (w_funct3)
                3'b000:  w_aluOp = (w_isOp && if_inst[30]) ? ALU_SUB : ALU_ADD;
                3'b001:  w_aluOp = ALU_SLL;
                3'b010:  w_aluOp = ALU_SLT;
                3'b011:  w_aluOp = ALU_SLTU;
                3'b100:  w_aluOp = ALU_XOR;
                3'b101:  w_aluOp = if_inst[30] ? ALU_SRA : ALU_SRL;
                3'b110:  w_aluOp = ALU_OR;
                default: w_aluOp = ALU_AND;
            endcase
        end
    end

    // Operand selection per format; immediate shifts take a 5-bit shamt
    always_comb begin
        w_op1 = 32'd0;
        w_op2 = 32'd0;
        if (w_isOp) begin
            w_op1 = w_src1;
            w_op2 = w_src2;
        end else if (w_isOpImm) begin
            w_op1 = w_src1;
            w_op2 = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? w_shamt : w_immI;
        end else if (w_isLoad) begin
            w_op1 = w_src1;
            w_op2 = w_immI;
        end else if (w_isLui) begin
            w_op2 = w_immU;
        end
    end

    // Output register: flush beats hazard beats normal capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_pc      <= 32'd0;
            r_op1     <= 32'd0;
            r_op2     <= 32'd0;
            r_waddr   <= 5'd0;
            r_wreg    <= 1'b0;
            r_aluOp   <= ALU_ADD;
            r_isLoad  <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_loadEn) begin
            if (w_hazard) begin
                r_valid <= 1'b0;
            end else begin
                r_valid   <= if_valid;
                r_pc      <= if_pc;
                r_op1     <= w_op1;
                r_op2     <= w_op2;
                r_waddr   <= w_rd;
                r_wreg    <= w_legal && (w_rd != 5'd0);
                r_aluOp   <= w_aluOp;
                r_isLoad  <= w_isLoad;
                r_illegal <= !w_legal;
            end
        end
    end

    assign id_valid   = r_valid;
    assign id_pc      = r_pc;
    assign id_op1     = r_op1;
    assign id_op2     = r_op2;
    assign id_waddr   = r_waddr;
    assign id_wreg    = r_wreg;
    assign id_alu_op  = r_aluOp;
    assign id_is_load = r_isLoad;
    assign id_illegal = r_illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized
// traffic compared against a behavioural decode/pipeline model.
// Build option: ID_FWD_EN selects the forwarding variant of the expectations.
module tb_id_stage;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] LOAD   = 7'b0000011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  waddr;
        logic        wreg;
        logic [3:0]  alu;
        logic        isLoad;
        logic        illegal;
    } outT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_inst;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        ex_wreg, ex_is_load, flush, ex_ready;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        id_valid, id_wreg, id_is_load, id_illegal;
    logic [31:0] id_pc, id_op1, id_op2;
    logic [4:0]  id_waddr;
    logic [3:0]  id_alu_op;

    logic [31:0] regs [32];
    logic [3:0]  aluTab [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    int          checks = 0;
    int          errors = 0;
    logic        mValid = 1'b0;
    outT         mOut;

    id_stage dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .flush(flush), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_op1(id_op1), .id_op2(id_op2),
        .id_waddr(id_waddr), .id_wreg(id_wreg), .id_alu_op(id_alu_op),
        .id_is_load(id_is_load), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    // Register file model; x0 deliberately holds garbage so the DUT must zero it
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
    end

    function automatic logic [31:0] mkR(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP};
    endfunction

    function automatic logic [31:0] mkI(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic outT actualOut();
        return {id_pc, id_op1, id_op2, id_waddr, id_wreg, id_alu_op, id_is_load, id_illegal};
    endfunction

    function automatic logic [31:0] srcVal(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef ID_FWD_EN
        if (ex_wreg && ex_waddr == r && !ex_is_load) return ex_wdata;
`endif
        return regs[r];
    endfunction

    function automatic logic modelHazard();
        logic [6:0] opc;
        logic [4:0] srcs [2];
        logic       uses [2];
        opc = if_inst[6:0];
        srcs[0] = if_inst[19:15];
        srcs[1] = if_inst[24:20];
        uses[0] = (opc == OP) || (opc == OPIMM) || (opc == LOAD);
        uses[1] = (opc == OP);
        if (!if_valid) return 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (uses[i] && srcs[i] != 5'd0 && ex_wreg && ex_waddr == srcs[i]) begin
`ifdef ID_FWD_EN
                if (ex_is_load) return 1'b1;
`else
                return 1'b1;
`endif
            end
        end
        return 1'b0;
    endfunction

    function automatic outT modelDecode();
        outT         o;
        logic [2:0]  f3;
        logic [31:0] sext;
        o = '0;
        f3 = if_inst[14:12];
        sext = 32'($signed(if_inst[31:20]));
        o.pc = if_pc;
        o.waddr = if_inst[11:7];
        case (if_inst[6:0])
            OP: begin
                o.op1 = srcVal(if_inst[19:15]);
                o.op2 = srcVal(if_inst[24:20]);
                o.alu = aluTab[f3] + (((f3 == 3'd0 || f3 == 3'd5) && if_inst[30]) ? 4'd1 : 4'd0);
            end
            OPIMM: begin
                o.op1 = srcVal(if_inst[19:15]);
                o.op2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, if_inst[24:20]} : sext;
                o.alu = aluTab[f3] + ((f3 == 3'd5 && if_inst[30]) ? 4'd1 : 4'd0);
            end
            LOAD: begin
                o.op1 = srcVal(if_inst[19:15]);
                o.op2 = sext;
                o.isLoad = 1'b1;
            end
            LUI:     o.op2 = {if_inst[31:12], 12'd0};
            default: o.illegal = 1'b1;
        endcase
        o.wreg = !o.illegal && (o.waddr != 5'd0);
        return o;
    endfunction

    function automatic logic modelIfReady();
        return flush || ((!mValid || ex_ready) && !modelHazard());
    endfunction

    function automatic logic [31:0] randInst();
        int         k;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        logic [6:0] opc;
        logic [11:0] imm;
        k   = $urandom_range(0, 9);
        f3  = 3'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        imm = 12'($urandom);
        if (k <= 2) begin
            return mkR(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                       rs2, rs1, f3, rd);
        end else if (k <= 5) begin
            if (f3 == 3'd1) imm = {7'h00, rs2};
            if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rs2};
            return mkI(imm, rs1, f3, rd, OPIMM);
        end else if (k <= 7) begin
            return mkI(imm, rs1, 3'b010, rd, LOAD);
        end else if (k == 8) begin
            return {20'($urandom), rd, LUI};
        end
        do opc = 7'($urandom); while (opc == OP || opc == OPIMM || opc == LUI || opc == LOAD);
        return {25'($urandom), opc};
    endfunction

    task automatic setIdle();
        if_valid = 1'b0; if_pc = 32'd0; if_inst = 32'd0;
        ex_wreg = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0; ex_is_load = 1'b0;
        ex_ready = 1'b1; flush = 1'b0;
    endtask

    // Advance one clock edge and update the reference pipeline from the
    // inputs that were present at that edge
    task automatic stepModel();
        logic le, hz;
        outT  n;
        le = !mValid || ex_ready;
        hz = modelHazard();
        n  = modelDecode();
        @(posedge clk);
        #1;
        if (flush) mValid = 1'b0;
        else if (le) begin
            if (hz) mValid = 1'b0;
            else begin
                mValid = if_valid;
                if (if_valid) mOut = n;
            end
        end
    endtask

    task automatic test_reset();
        setIdle();
        if_valid = 1'b1;
        if_inst = mkI(12'd5, 5'd0, 3'd0, 5'd1, OPIMM);
        #1;
        checks++;
        if (if_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_if_ready got %b want 0", if_ready); end
        @(posedge clk);
        #1;
        checks++;
        if ({id_valid, actualOut()} !== '0) begin
            errors++; $display("[TB] FAIL reset_outputs got %b/%h want all zero", id_valid, actualOut());
        end
        rst = 1'b1;
        mValid = 1'b0;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_if_ready got %b want 1", if_ready); end
        setIdle();
    endtask

    task automatic test_addi();
        setIdle();
        if_valid = 1'b1;
        if_pc = 32'h100;
        if_inst = mkI(12'd5, 5'd0, 3'd0, 5'd1, OPIMM);
        #1;
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("[TB] FAIL addi_if_ready got %b want 1", if_ready); end
        stepModel();
        checks++;
        if ({id_valid, id_pc, id_op1, id_op2, id_alu_op, id_waddr, id_wreg, id_illegal} !==
            {1'b1, 32'h100, 32'd0, 32'd5, 4'd0, 5'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL addi got v=%b pc=%h op1=%h op2=%h alu=%0d wa=%0d wr=%b want 1 100 0 5 0 1 1",
                     id_valid, id_pc, id_op1, id_op2, id_alu_op, id_waddr, id_wreg);
        end
        setIdle();
        stepModel();
    endtask

    task automatic test_forward();
        setIdle();
        regs[1] = 32'h55; regs[2] = 32'h7;
        if_valid = 1'b1; if_pc = 32'h104;
        if_inst = mkR(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        ex_wreg = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'h10;
        #1;
`ifdef ID_FWD_EN
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("[TB] FAIL fwd_if_ready got %b want 1", if_ready); end
        stepModel();
`else
        checks++;
        if (if_ready !== 1'b0) begin errors++; $display("[TB] FAIL nofwd_stall got %b want 0", if_ready); end
        stepModel();
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL nofwd_bubble got %b want 0", id_valid); end
        ex_wreg = 1'b0;
        regs[1] = 32'h10;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("[TB] FAIL nofwd_resume got %b want 1", if_ready); end
        stepModel();
`endif
        checks++;
        if ({id_valid, id_op1, id_op2, id_waddr, id_alu_op} !== {1'b1, 32'h10, 32'h7, 5'd3, 4'd0}) begin
            errors++;
            $display("[TB] FAIL add_fwd got v=%b op1=%h op2=%h wa=%0d alu=%0d want 1 10 7 3 0",
                     id_valid, id_op1, id_op2, id_waddr, id_alu_op);
        end
        setIdle();
        stepModel();
    endtask

    task automatic test_load_use();
        setIdle();
        regs[5] = 32'hABC;
        if_valid = 1'b1; if_pc = 32'h108;
        if_inst = mkR(7'h00, 5'd0, 5'd5, 3'd0, 5'd6);
        ex_wreg = 1'b1; ex_waddr = 5'd5; ex_is_load = 1'b1; ex_wdata = 32'hDEAD;
        #1;
        checks++;
        if (if_ready !== 1'b0) begin errors++; $display("[TB] FAIL loaduse_if_ready got %b want 0", if_ready); end
        stepModel();
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL loaduse_bubble got %b want 0", id_valid); end
        ex_wreg = 1'b0; ex_is_load = 1'b0;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("[TB] FAIL loaduse_resume got %b want 1", if_ready); end
        stepModel();
        checks++;
        if ({id_valid, id_op1, id_op2, id_waddr, id_wreg} !== {1'b1, 32'hABC, 32'd0, 5'd6, 1'b1}) begin
            errors++;
            $display("[TB] FAIL loaduse_issue got v=%b op1=%h op2=%h wa=%0d wr=%b want 1 abc 0 6 1",
                     id_valid, id_op1, id_op2, id_waddr, id_wreg);
        end
        setIdle();
        stepModel();
    endtask

    task automatic test_stall_flush();
        setIdle();
        regs[2] = 32'd100;
        if_valid = 1'b1; if_pc = 32'h200;
        if_inst = mkI(12'hFFD, 5'd2, 3'd0, 5'd4, OPIMM);
        #1;
        stepModel();
        checks++;
        if ({id_valid, id_op1, id_op2} !== {1'b1, 32'd100, 32'hFFFF_FFFD}) begin
            errors++; $display("[TB] FAIL addi_neg got v=%b op1=%h op2=%h want 1 64 fffffffd", id_valid, id_op1, id_op2);
        end
        ex_ready = 1'b0;
        if_pc = 32'h204;
        if_inst = mkR(7'h00, 5'd2, 5'd1, 3'd4, 5'd9);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (if_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_if_ready[%0d] got %b want 0", i, if_ready); end
            stepModel();
            checks++;
            if ({id_valid, id_pc, id_op1, id_op2, id_waddr} !== {1'b1, 32'h200, 32'd100, 32'hFFFF_FFFD, 5'd4}) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d] got v=%b pc=%h op1=%h op2=%h wa=%0d want 1 200 64 fffffffd 4",
                         i, id_valid, id_pc, id_op1, id_op2, id_waddr);
            end
        end
        flush = 1'b1;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_if_ready got %b want 1", if_ready); end
        stepModel();
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b want 0", id_valid); end
        setIdle();
        stepModel();
    endtask

    task automatic test_flush_hazard();
        setIdle();
        if_valid = 1'b1;
        if_inst = mkR(7'h00, 5'd3, 5'd1, 3'd0, 5'd2);
        ex_wreg = 1'b1; ex_waddr = 5'd1; ex_is_load = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_hazard_if_ready got %b want 1", if_ready); end
        stepModel();
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_hazard_valid got %b want 0", id_valid); end
        setIdle();
        stepModel();
    endtask

    task automatic test_reset_mid_illegal();
        setIdle();
        if_valid = 1'b1; if_pc = 32'h300;
        if_inst = {12'h123, 5'd3, 3'd0, 5'd7, 7'b1111111};
        #1;
        stepModel();
        checks++;
        if ({id_valid, id_illegal, id_wreg} !== 3'b110) begin
            errors++; $display("[TB] FAIL illegal got v=%b ill=%b wr=%b want 1 1 0", id_valid, id_illegal, id_wreg);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({id_valid, id_illegal, id_wreg, id_pc, if_ready} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset got v=%b ill=%b wr=%b pc=%h rdy=%b want all zero",
                     id_valid, id_illegal, id_wreg, id_pc, if_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        mValid = 1'b0;
        setIdle();
    endtask

    task automatic test_random();
        logic holdInst = 1'b0;
        logic expRdy;
        for (int c = 0; c < 500; c++) begin
            if (!holdInst) begin
                if_valid = ($urandom_range(0, 9) < 8);
                if_inst  = randInst();
                if_pc    = $urandom;
            end
            ex_wreg    = 1'($urandom_range(0, 1));
            ex_waddr   = 5'($urandom_range(0, 7));
            ex_wdata   = $urandom;
            ex_is_load = ($urandom_range(0, 3) == 0);
            ex_ready   = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            #1;
            expRdy = modelIfReady();
            checks++;
            if (if_ready !== expRdy) begin
                errors++; $display("[TB] FAIL rand_if_ready[%0d] got %b want %b", c, if_ready, expRdy);
            end
            holdInst = if_valid && !expRdy;
            stepModel();
            checks++;
            if (id_valid !== mValid) begin
                errors++; $display("[TB] FAIL rand_valid[%0d] got %b want %b", c, id_valid, mValid);
            end
            if (mValid) begin
                checks++;
                if (actualOut() !== mOut) begin
                    errors++; $display("[TB] FAIL rand_fields[%0d] got %h want %h", c, actualOut(), mOut);
                end
            end
        end
        setIdle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom | 32'h1;
        setIdle();
        test_reset();
        test_addi();
        test_forward();
        test_load_use();
        test_stall_flush();
        test_flush_hazard();
        test_reset_mid_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
